// File: rtl/ula_8bit_pkg.sv
// Shared types and constants for the 8-bit ALU: opcode encoding and datapath width.
package ula_pkg;

  localparam int WIDTH = 8;
  localparam int SEL_W = 3;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NOT  = 3'b011,
    OP_EQ   = 3'b100,
    OP_ADD  = 3'b101,
    OP_MUX  = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  // Single-bit equality flag widened to the result width.
  function automatic logic [WIDTH-1:0] eq_flag(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    eq_flag = {{(WIDTH-1){1'b0}}, (x == y)};
  endfunction

  // Selected operand bit, zero-extended to the result width.
  function automatic logic [WIDTH-1:0] bit_select(input logic [WIDTH-1:0] x,
                                                  input logic [SEL_W-1:0] sel);
    bit_select = {{(WIDTH-1){1'b0}}, x[sel]};
  endfunction

endpackage

// File: rtl/ula_8bit_if.sv
// Operand/result bundle between the datapath driver and the ALU.
interface ula_8bit_if #(
  parameter int WIDTH = ula_pkg::WIDTH
);

  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] s;
  logic             cout;

  modport master (
    output op,
    output a,
    output b,
    output cin,
    input  s,
    input  cout
  );

  modport slave (
    input  op,
    input  a,
    input  b,
    input  cin,
    output s,
    output cout
  );

endinterface

// File: rtl/ula_8bit_adder.sv
// 8-bit ripple-carry adder built from full-adder bit slices; purely combinational.
module ula_adder8 (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  output logic [7:0] o_sum,
  output logic       o_cout
);

  logic [8:0] w_carry;
  logic [7:0] w_prop;

  assign w_carry[0] = i_cin;

  for (genvar gi = 0; gi < 8; gi++) begin : g_fa
    assign w_prop[gi]      = i_a[gi] ^ i_b[gi];
    assign o_sum[gi]       = w_prop[gi] ^ w_carry[gi];
    assign w_carry[gi + 1] = (i_a[gi] & i_b[gi]) | (w_carry[gi] & w_prop[gi]);
  end

  assign o_cout = w_carry[8];

endmodule

// File: rtl/ula_8bit.sv
// 8-bit ALU: opcode-selected logic/compare/add/bit-select with one cycle of latency.
module ula_8bit
  import ula_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  ula_8bit_if.slave   bus
);

  logic [WIDTH-1:0] w_sum;
  logic             w_sum_cout;
  logic [WIDTH-1:0] w_s;
  logic             w_cout;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  op_e              w_op;

  assign w_op = op_e'(bus.op);

  ula_adder8 u_adder (
    .i_a    (bus.a),
    .i_b    (bus.b),
    .i_cin  (bus.cin),
    .o_sum  (w_sum),
    .o_cout (w_sum_cout)
  );

  // Result decode; cin and the adder carry only reach the outputs on ADD.
  always_comb begin
    w_s    = {WIDTH{1'b0}};
    w_cout = 1'b0;
    case (w_op)
      OP_AND: w_s = bus.a & bus.b;
      OP_OR:  w_s = bus.a | bus.b;
      OP_XOR: w_s = bus.a ^ bus.b;
      OP_NOT: w_s = ~bus.a;
      OP_EQ:  w_s = eq_flag(bus.a, bus.b);
      OP_ADD: begin
        w_s    = w_sum;
        w_cout = w_sum_cout;
      end
      OP_MUX: w_s = bit_select(bus.a, bus.b[SEL_W-1:0]);
      default: begin
        w_s    = {WIDTH{1'b0}};
        w_cout = 1'b0;
      end
    endcase
  end

  // Output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s    <= {WIDTH{1'b0}};
      r_cout <= 1'b0;
    end else begin
      r_s    <= w_s;
      r_cout <= w_cout;
    end
  end

  assign bus.s    = r_s;
  assign bus.cout = r_cout;

endmodule

// File: tb/tb_ula_8bit.sv
// Self-checking bench for ula_8bit: directed vectors plus random stimulus against an arithmetic model.
module tb_ula_8bit;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  ula_8bit_if u_if ();

  ula_8bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: results from the opcode rules using plain integer arithmetic.
  function automatic void ref_model(input int op, input int a, input int b, input int cin,
                                    output int s, output int c);
    int sum;
    s = 0;
    c = 0;
    case (op)
      0: s = a & b;
      1: s = a | b;
      2: s = a ^ b;
      3: s = 255 - a;
      4: s = (a == b) ? 1 : 0;
      5: begin
        sum = a + b + cin;
        s   = sum % 256;
        c   = sum / 256;
      end
      6: s = (a / (1 << (b % 8))) % 2;
      default: s = 0;
    endcase
  endfunction

  task automatic apply(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic cin);
    u_if.op  = op;
    u_if.a   = a;
    u_if.b   = b;
    u_if.cin = cin;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    apply(3'b101, 8'd220, 8'd55, 1'b0);
    #2;
    n_tests++;
    if (u_if.s !== 8'd0 || u_if.cout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_initial: s=%0d cout=%0d, required s=0 cout=0", u_if.s, u_if.cout);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (u_if.s !== 8'd19 || u_if.cout !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_prefill: s=%0d cout=%0d, required s=19 cout=1", u_if.s, u_if.cout);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (u_if.s !== 8'd0 || u_if.cout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: s=%0d cout=%0d, required s=0 cout=0", u_if.s, u_if.cout);
    end
    @(posedge clk); #1;
    n_tests++;
    if (u_if.s !== 8'd0 || u_if.cout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: s=%0d cout=%0d, required s=0 cout=0", u_if.s, u_if.cout);
    end
    rst_n = 1'b1;
    apply(3'b101, 8'd10, 8'd22, 1'b0);
    @(posedge clk); #1;
    n_tests++;
    if (u_if.s !== 8'd32 || u_if.cout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_result: s=%0d cout=%0d, required s=32 cout=0", u_if.s, u_if.cout);
    end
  endtask

  task automatic test_logic;
    logic [7:0] va   [2] = '{8'b00100110, 8'b11010111};
    logic [7:0] vb   [2] = '{8'b00101011, 8'b01011011};
    logic [7:0] vexp [8] = '{8'b00100010, 8'b00101111, 8'b00001101, 8'b11011001,
                             8'b01010011, 8'b11011111, 8'b10001100, 8'b00101000};
    for (int v = 0; v < 2; v++) begin
      for (int o = 0; o < 4; o++) begin
        apply(o[2:0], va[v], vb[v], 1'b1);
        @(posedge clk); #1;
        n_tests++;
        if (u_if.s !== vexp[v*4+o] || u_if.cout !== 1'b0) begin
          n_fail++;
          $display("FAIL logic_op%0d_v%0d: s=%b cout=%b, required s=%b cout=0",
                   o, v, u_if.s, u_if.cout, vexp[v*4+o]);
        end
      end
    end
  endtask

  task automatic test_eq;
    logic [7:0] ea   [4] = '{8'b00100110, 8'd3, 8'd3, 8'd0};
    logic [7:0] eb   [4] = '{8'b00100110, 8'd7, 8'd3, 8'd0};
    logic [7:0] eexp [4] = '{8'd1, 8'd0, 8'd1, 8'd1};
    for (int i = 0; i < 4; i++) begin
      apply(3'b100, ea[i], eb[i], 1'bx);
      @(posedge clk); #1;
      n_tests++;
      if (u_if.s !== eexp[i] || u_if.cout !== 1'b0) begin
        n_fail++;
        $display("FAIL eq_%0d: s=%b cout=%b, required s=%b cout=0", i, u_if.s, u_if.cout, eexp[i]);
      end
    end
  endtask

  task automatic test_add;
    logic [7:0] aa [4] = '{8'd10, 8'd10, 8'd220, 8'd255};
    logic [7:0] ab [4] = '{8'd22, 8'd1,  8'd55,  8'd255};
    logic       ac [4] = '{1'b0,  1'b1,  1'b0,   1'b1};
    logic [7:0] as [4] = '{8'd32, 8'd12, 8'd19,  8'd255};
    logic       ao [4] = '{1'b0,  1'b0,  1'b1,   1'b1};
    for (int i = 0; i < 4; i++) begin
      apply(3'b101, aa[i], ab[i], ac[i]);
      @(posedge clk); #1;
      n_tests++;
      if (u_if.s !== as[i] || u_if.cout !== ao[i]) begin
        n_fail++;
        $display("FAIL add_%0d: s=%0d cout=%b, required s=%0d cout=%b",
                 i, u_if.s, u_if.cout, as[i], ao[i]);
      end
    end
  endtask

  task automatic test_mux;
    logic [7:0] mexp [8] = '{8'd0, 8'd1, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0};
    for (int i = 0; i < 8; i++) begin
      apply(3'b110, 8'b00100110, i[7:0], 1'bx);
      @(posedge clk); #1;
      n_tests++;
      if (u_if.s !== mexp[i] || u_if.cout !== 1'b0) begin
        n_fail++;
        $display("FAIL mux_sel%0d: s=%b cout=%b, required s=%b cout=0", i, u_if.s, u_if.cout, mexp[i]);
      end
    end
    apply(3'b110, 8'b00100110, 8'hF9, 1'b1);
    @(posedge clk); #1;
    n_tests++;
    if (u_if.s !== 8'd1 || u_if.cout !== 1'b0) begin
      n_fail++;
      $display("FAIL mux_upper_ignored: s=%b cout=%b, required s=00000001 cout=0", u_if.s, u_if.cout);
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] seq [4] = '{3'b000, 3'b101, 3'b100, 3'b111};
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    int         es;
    int         ec;
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (i % 8 == 2) ? ra : 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      apply(seq[i % 4], ra, rb, rc);
      ref_model(int'(seq[i % 4]), int'(ra), int'(rb), int'(rc), es, ec);
      @(posedge clk); #1;
      n_tests++;
      if (u_if.s !== 8'(es) || u_if.cout !== 1'(ec)) begin
        n_fail++;
        $display("FAIL b2b_%0d op%0d: s=%0d cout=%b, required s=%0d cout=%0d",
                 i, seq[i % 4], u_if.s, u_if.cout, es, ec);
      end
    end
  endtask

  task automatic test_random;
    logic [2:0] rop;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    int         es;
    int         ec;
    for (int i = 0; i < 300; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      rc  = 1'($urandom_range(0, 1));
      apply(rop, ra, rb, rc);
      ref_model(int'(rop), int'(ra), int'(rb), int'(rc), es, ec);
      @(posedge clk); #1;
      n_tests++;
      if (u_if.s !== 8'(es) || u_if.cout !== 1'(ec)) begin
        n_fail++;
        $display("FAIL rand_%0d op%0d a=%0d b=%0d cin=%b: s=%0d cout=%b, required s=%0d cout=%0d",
                 i, rop, ra, rb, rc, u_if.s, u_if.cout, es, ec);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    #1;
    test_reset();
    test_logic();
    test_eq();
    test_add();
    test_mux();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ula_8bit.md
Name: ula_8bit

Overview:
- 8-bit arithmetic/logic unit with registered outputs, one result per clock.
- Operations, selected by a 3-bit opcode: AND, OR, XOR, NOT, equality compare, add with carry, and 8:1 bit select.
- Sits in the datapath as a single-cycle-latency execution unit. Operands and opcode are sampled every rising clock edge.

Parameters:
- WIDTH, 8, operand/result width. Only 8 is required to be supported. The mux select is always b[2:0].

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- op  input  3  operation select
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B; for the MUX op, only b[2:0] is used as the select
- cin  input  1  carry-in, used only by ADD
- s  output  WIDTH  registered result
- cout  output  1  registered carry-out

Behaviour:
- Reset:
  - rst_n low immediately (asynchronously) forces s=0 and cout=0.
  - The reset is released synchronously to clk by the surrounding logic. The block samples inputs on the first rising edge after release.
- Latency:
  - Combinational result f(op,a,b,cin) is captured into s/cout on every rising clk edge when rst_n is high.
  - Outputs reflect the inputs present at the previous edge. No handshake, no stall; throughput is 1 op/cycle.
- Opcodes (constants in the package):
  - 000 AND: s = a & b; cout = 0.
  - 001 OR: s = a | b; cout = 0.
  - 010 XOR: s = a ^ b; cout = 0.
  - 011 NOT: s = ~a; b ignored; cout = 0.
  - 100 EQ: s = 8'h01 if a == b, else 8'h00; cout = 0.
  - 101 ADD: {cout, s} = a + b + cin, a 9-bit unsigned sum. The sum wraps modulo 256 and cout is the 9th bit.
  - 110 MUX: s = {7'b0, a[b[2:0]]}; b[7:3] ignored; cout = 0.
  - 111 reserved: s = 0, cout = 0.
- Operand use:
  - cin is ignored for every op except ADD. An X/unknown cin on non-ADD ops must not propagate to s or cout.
  - Operands not used by the current op are ignored and must not affect outputs.
- Boundary cases:
  - ADD with a=8'hFF, b=8'hFF, cin=1 gives s=8'hFF, cout=1.
  - EQ with a=b=0 gives s=8'h01.
  - Opcode changing every cycle gives each result exactly one cycle later, with no blending.
- Reset mid-operation: the pending result is discarded and outputs go to 0 immediately. The first valid result appears one edge after the first sampling edge following release.
- No internal state other than the output registers.

Decomposition:
- Package ula_pkg:
  - Opcode typedef, a 3-bit enum: OP_AND, OP_OR, OP_XOR, OP_NOT, OP_EQ, OP_ADD, OP_MUX, OP_RSVD.
  - WIDTH default constant.
- One sub-module, ula_adder8: an 8-bit ripple-carry adder built from full-adder bit slices. Inputs a, b, cin; outputs sum, cout; purely combinational.
- The top level holds the op decode mux, the equality compare, the bit-select mux, and the output registers.

Test Plan:
- Reset: assert rst_n=0 mid-stream with op=ADD, a=220, b=55 -> s=0, cout=0 immediately, without waiting for a clock edge. Release, then apply inputs -> result appears one edge after the first sampling edge.
- Logic ops, with a=8'b00100110, b=8'b00101011 -> after one edge:
  - AND s=00100010
  - OR s=00101111
  - XOR s=00001101
  - NOT s=11011001
  - cout=0 in all cases. Repeat with a=11010111, b=01011011 -> AND 01010011, OR 11011111, XOR 10001100, NOT 00101000.
- EQ:
  - a=b=8'b00100110 -> s=00000001.
  - a=3, b=7 -> s=00000000.
  - a=b=3 -> s=00000001.
  - cin=X throughout -> outputs stay clean.
- ADD:
  - 10+22, cin=0 -> s=32, cout=0.
  - 10+1, cin=1 -> s=12, cout=0.
  - 220+55, cin=0 -> s=19, cout=1.
  - 255+255, cin=1 -> s=255, cout=1.
- MUX: a=8'b00100110, b=0..7 -> s = 0,1,1,0,0,1,0,0 (in bit 0, upper bits 0). b=8'hF9 -> s=1, since the upper bits of b are ignored.
- Back-to-back ops: change op every cycle AND -> ADD -> EQ -> 111 -> each output matches its op exactly one cycle later; op 111 -> s=0, cout=0.
